// File: rtl/gps_zda_parser.sv
// gps_zda_parser: decodes $GPZDA NMEA sentences into ASCII UTC time/date.
// Define GPS_ZDA_CKSUM_EN to verify the trailing *hh checksum.
module gps_zda_parser #(
  parameter int B = 8,
  parameter logic [6*B-1:0] Prefix = "$GPZDA",
  parameter logic [B-1:0] Separator = ",",
  parameter int MaxLen = 82
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic [B-1:0]   data,
  output logic           valid_out,
  output logic           error_out,
  output logic [6*B-1:0] time_hms,
  output logic [2*B-1:0] day,
  output logic [2*B-1:0] month,
  output logic [4*B-1:0] year
);
  localparam int CW = $clog2(MaxLen + 2);
  localparam logic [CW-1:0] Limit = CW'(MaxLen + 1);
  localparam logic [B-1:0] Dollar = Prefix[6*B-1 -: B];
  localparam logic [B-1:0] Star = B'(8'h2A);
  localparam logic [B-1:0] Cr = B'(8'h0D);
  localparam logic [B-1:0] Lf = B'(8'h0A);
  localparam logic [B-1:0] Zero = B'(8'h30);
  localparam logic [B-1:0] Nine = B'(8'h39);

  typedef enum logic [2:0] {
    IDLE, PREFIX, SEP, FIELDS,
    CKSUM_HI, CKSUM_LO, WAIT_EOL, DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0] pi_q, pi_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [2:0] fld_q, fld_d;
  logic [3:0] len_q [4];
  logic [3:0] len_d [4];
  logic bad_q, bad_d;
  logic pass_q, pass_d;
  logic [6*B-1:0] sh_t_q, sh_t_d, time_q, time_d;
  logic [2*B-1:0] sh_d_q, sh_d_d, day_q, day_d;
  logic [2*B-1:0] sh_m_q, sh_m_d, month_q, month_d;
  logic [4*B-1:0] sh_y_q, sh_y_d, year_q, year_d;
  logic is_eol, is_dig, fok;
  logic [1:0] fi;

  assign is_eol = (data == Cr) || (data == Lf);
  assign is_dig = (data >= Zero) && (data <= Nine);
  assign cnt_n = cnt_q + CW'(1);
  assign fi = 2'(fld_q - 3'd1);
  assign fok = (len_q[0] >= 4'd6) && (len_q[1] == 4'd2) &&
               (len_q[2] == 4'd2) && (len_q[3] == 4'd4) &&
               !bad_q && (fld_q >= 3'd4);

`ifdef GPS_ZDA_CKSUM_EN
  logic [B-1:0] xor_q, xor_d, cks_q, cks_d;
  logic [3:0] hi_q, hi_d, hex_v;
  logic hex_ok, ck_ok;

  // Decode one ASCII hex digit, either case.
  always_comb begin
    hex_ok = 1'b1;
    hex_v = '0;
    if (is_dig) hex_v = 4'(data - Zero);
    else if (data >= B'(8'h41) && data <= B'(8'h46))
      hex_v = 4'(data - B'(8'h37));
    else if (data >= B'(8'h61) && data <= B'(8'h66))
      hex_v = 4'(data - B'(8'h57));
    else hex_ok = 1'b0;
  end

  assign ck_ok = (cks_q == xor_q);

  // Running XOR of the body and capture of the received digits.
  always_comb begin
    xor_d = xor_q;
    hi_d = hi_q;
    cks_d = cks_q;
    if (load) begin
      if (data == Dollar) xor_d = '0;
      else if ((state_q == PREFIX || state_q == SEP ||
                state_q == FIELDS) && data != Star && !is_eol)
        xor_d = xor_q ^ data;
      if (state_q == CKSUM_HI) hi_d = hex_v;
      if (state_q == CKSUM_LO) cks_d = B'({hi_q, hex_v});
    end
  end

  // Checksum registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xor_q <= '0;
      hi_q <= '0;
      cks_q <= '0;
    end else begin
      xor_q <= xor_d;
      hi_q <= hi_d;
      cks_q <= cks_d;
    end
  end
`endif

  // Sentence FSM: next state, field capture and output update.
  always_comb begin
    state_d = state_q;
    pi_d = pi_q;
    cnt_d = cnt_q;
    fld_d = fld_q;
    len_d = len_q;
    bad_d = bad_q;
    pass_d = 1'b0;
    sh_t_d = sh_t_q;
    sh_d_d = sh_d_q;
    sh_m_d = sh_m_q;
    sh_y_d = sh_y_q;
    time_d = time_q;
    day_d = day_q;
    month_d = month_q;
    year_d = year_q;
    if (state_q == DONE) state_d = IDLE;
    if (load) begin
      if (data == Dollar) begin
        state_d = PREFIX;
        pi_d = 3'd1;
        cnt_d = CW'(1);
        fld_d = 3'd1;
        len_d = '{default: '0};
        bad_d = 1'b0;
      end else if (state_q == IDLE || state_q == DONE) begin
        state_d = IDLE;
      end else if (cnt_n == Limit) begin
        state_d = DONE;
      end else begin
        cnt_d = cnt_n;
        case (state_q)
          PREFIX: begin
            if (data != Prefix[(5 - int'(pi_q)) * B +: B])
              state_d = IDLE;
            else if (pi_q == 3'd5) state_d = SEP;
            else pi_d = pi_q + 3'd1;
          end
          SEP: state_d = (data == Separator) ? FIELDS : IDLE;
          FIELDS: begin
            if (data == Star) begin
`ifdef GPS_ZDA_CKSUM_EN
              state_d = CKSUM_HI;
`else
              state_d = WAIT_EOL;
`endif
            end else if (is_eol) begin
              state_d = DONE;
`ifdef GPS_ZDA_CKSUM_EN
              pass_d = 1'b0;
`else
              pass_d = fok;
`endif
            end else if (data == Separator) begin
              if (fld_q != 3'd7) fld_d = fld_q + 3'd1;
            end else if (fld_q <= 3'd4) begin
              if (len_q[fi] != 4'hF) len_d[fi] = len_q[fi] + 4'd1;
              if (fld_q == 3'd1 && len_q[fi] < 4'd6) begin
                sh_t_d = {sh_t_q[5*B-1:0], data};
                bad_d = bad_q | !is_dig;
              end else if (fld_q == 3'd2 && len_q[fi] < 4'd2) begin
                sh_d_d = {sh_d_q[B-1:0], data};
                bad_d = bad_q | !is_dig;
              end else if (fld_q == 3'd3 && len_q[fi] < 4'd2) begin
                sh_m_d = {sh_m_q[B-1:0], data};
                bad_d = bad_q | !is_dig;
              end else if (fld_q == 3'd4 && len_q[fi] < 4'd4) begin
                sh_y_d = {sh_y_q[3*B-1:0], data};
                bad_d = bad_q | !is_dig;
              end
            end
          end
`ifdef GPS_ZDA_CKSUM_EN
          CKSUM_HI: state_d = hex_ok ? CKSUM_LO : DONE;
          CKSUM_LO: state_d = hex_ok ? WAIT_EOL : DONE;
`endif
          WAIT_EOL: begin
            if (is_eol) begin
              state_d = DONE;
`ifdef GPS_ZDA_CKSUM_EN
              pass_d = fok && ck_ok;
`else
              pass_d = fok;
`endif
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    if (state_d == DONE && pass_d) begin
      time_d = sh_t_q;
      day_d = sh_d_q;
      month_d = sh_m_q;
      year_d = sh_y_q;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pi_q <= '0;
      cnt_q <= '0;
      fld_q <= '0;
      len_q <= '{default: '0};
      bad_q <= 1'b0;
      pass_q <= 1'b0;
      sh_t_q <= '0;
      sh_d_q <= '0;
      sh_m_q <= '0;
      sh_y_q <= '0;
      time_q <= '0;
      day_q <= '0;
      month_q <= '0;
      year_q <= '0;
    end else begin
      state_q <= state_d;
      pi_q <= pi_d;
      cnt_q <= cnt_d;
      fld_q <= fld_d;
      len_q <= len_d;
      bad_q <= bad_d;
      pass_q <= pass_d;
      sh_t_q <= sh_t_d;
      sh_d_q <= sh_d_d;
      sh_m_q <= sh_m_d;
      sh_y_q <= sh_y_d;
      time_q <= time_d;
      day_q <= day_d;
      month_q <= month_d;
      year_q <= year_d;
    end
  end

  assign valid_out = (state_q == DONE) && pass_q;
  assign error_out = (state_q == DONE) && !pass_q;
  assign time_hms = time_q;
  assign day = day_q;
  assign month = month_q;
  assign year = year_q;
endmodule
